apb_fsm_controller: RTL
=======================

# apb_fsm_controller

APB-side control stage of the AHB-to-APB bridge, directly downstream of the AHB slave interface. Consumes the decoded `valid` strobe, the pipelined address/data copies and the registered write flag, and sequences APB SETUP/ENABLE phases to three peripherals. Stalls the AHB master through `Hreadyout` while an APB transfer is outstanding. Returns read data and an OKAY response.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `Hclk`  in  1  bridge clock, all state on rising edge.
- `Hresetn`  in  1  synchronous, active-low reset.
- `valid`  in  1  qualified AHB transfer in the current address phase.
- `Hwrite`  in  1  direction of the current address phase.
- `Hwritereg`  in  1  `Hwrite` delayed one cycle.
- `Haddr`, `Haddr1`, `Haddr2`  in  ADDR_W  address now, delayed 1, delayed 2 cycles.
- `Hwdata`, `Hwdata1`  in  DATA_W  write data now, delayed 1 cycle.
- `Prdata`  in  DATA_W  APB read data.
- `Pready`  in  1  APB wait control (only with `APB_WAIT_EN`).
- `Pselx`  out  3  one-hot peripheral select.
- `Penable`, `Pwrite`  out  1  APB enable / direction.
- `Paddr`  out  ADDR_W; `Pwdata`  out  DATA_W.
- `Hreadyout`  out  1  AHB ready.
- `Hrdata`  out  DATA_W  = `Prdata`, combinational.
- `Hresp`  out  2  constant 2'b00 (OKAY).

## Operation
- States: IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP.
- IDLE: valid&Hwrite→WWAIT; valid&!Hwrite→READ; else IDLE.
- WWAIT: valid→WRITEP; else WRITE.
- READ→RENABLE. WRITEP→WENABLEP. WRITE: valid→WENABLEP; else WENABLE.
- RENABLE, WENABLE: valid&!Hwrite→READ; valid&Hwrite→WWAIT; else IDLE.
- WENABLEP: !Hwritereg→READ; Hwritereg&valid→WRITEP; Hwritereg&!valid→WRITE.
- Outputs registered, loaded from next-state decode, so they align with the state register.
- Entering READ: Paddr←Haddr (pipelined read after ENABLE: Haddr), Pwrite←0.
- Entering WRITE: Paddr←Haddr1, Pwdata←Hwdata, Pwrite←1. Entering WRITEP: Paddr←Haddr2, Pwdata←Hwdata1, Pwrite←1.
- Pselx = decode(next Paddr): 0x8000_0000–0x83FF_FFFF→001, 0x8400_0000–0x87FF_FFFF→010, 0x8800_0000–0x8BFF_FFFF→100, else 000.
- Penable=1 only in *ENABLE states; Pselx/Paddr/Pwdata/Pwrite held SETUP→ENABLE; Pselx=0 in IDLE, WWAIT.
- Hreadyout=0 in READ, WRITE, WRITEP; 1 elsewhere.

## Timing
- Reset: state IDLE, Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1.
- Reset mid-transfer aborts at next edge; no partial ENABLE issued afterward.
- Read: address phase cycle 0 → SETUP cycle 1 → ENABLE cycle 2, Hrdata valid end of cycle 2; one wait state to AHB.
- Write: address cycle 0, data cycle 1 (WWAIT), SETUP cycle 2, ENABLE cycle 3.
- Back-to-back writes: WRITEP/WENABLEP path, one APB transfer every 2 cycles, no dropped data.
- valid is sampled only where the transition list uses it; elsewhere ignored.

## Configuration
- `APB_WAIT_EN` defined: `Pready` port present; each ENABLE state holds while Pready=0 with all APB outputs stable and Hreadyout=0; transitions from ENABLE taken only when Pready=1.
- Undefined: no `Pready` port; every ENABLE state lasts exactly one cycle.

## Structure
- Package `ahb2apb_pkg`: state enum, HTRANS constants, peripheral range bases/limits, `apb_sel_decode` function; shared with the slave interface.
- Sub-module `apb_out_reg`: output register bank (Paddr, Pwdata, Pwrite, Pselx, Penable, Hreadyout) with reset values; FSM stays in the top.

## Test plan
- Reset held 2 cycles with valid=1 → IDLE, Hreadyout=1, Pselx=000 throughout.
- Single read 0x8000_0010, Prdata=0xDEAD_BEEF → SETUP Pselx=001 Penable=0, ENABLE Penable=1, Hrdata=0xDEAD_BEEF, Hreadyout low one cycle.
- Single write 0x8400_0004 data 0x1234_5678 → Paddr=0x8400_0004, Pwdata=0x1234_5678, Pwrite=1, Pselx=010.
- Back-to-back writes 0x8800_0000/0xA, 0x8800_0004/0xB → two SETUP/ENABLE pairs, Pselx=100, data A then B in order.
- Write then read 0x8000_0008 → WENABLEP→READ, Pwrite drops to 0, correct Paddr.
- `APB_WAIT_EN`, Pready=0 for 3 cycles in RENABLE → outputs frozen, Hreadyout=0, completes when Pready=1; address 0x9000_0000 → Pselx=000.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared definitions for the AHB-to-APB bridge.
// Holds the APB control FSM state encoding, the HTRANS/HRESP codes,
// the peripheral address map and the peripheral select decoder.
package ahb2apb_pkg;

    // APB control FSM states. The encoding is fixed so that the debug
    // state port has a stable meaning across builds.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_RENABLE  = 3'd3,
        ST_WRITE    = 3'd4,
        ST_WRITEP   = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

    // AHB transfer types, consumed by the slave interface to form valid.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // The bridge only ever answers OKAY.
    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // Peripheral address map, 64 MiB per peripheral.
    localparam logic [31:0] PERIPH0_BASE  = 32'h8000_0000;
    localparam logic [31:0] PERIPH0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] PERIPH1_BASE  = 32'h8400_0000;
    localparam logic [31:0] PERIPH1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] PERIPH2_BASE  = 32'h8800_0000;
    localparam logic [31:0] PERIPH2_LIMIT = 32'h8BFF_FFFF;

    // One-hot peripheral select for an address; 000 outside the map.
    function automatic logic [2:0] apb_sel_decode(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if ((addr >= PERIPH0_BASE) && (addr <= PERIPH0_LIMIT)) begin
            sel = 3'b001;
        end else if ((addr >= PERIPH1_BASE) && (addr <= PERIPH1_LIMIT)) begin
            sel = 3'b010;
        end else if ((addr >= PERIPH2_BASE) && (addr <= PERIPH2_LIMIT)) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_out_reg.sv
// apb_out_reg: registered APB/AHB-side outputs of the bridge control
// stage. The FSM computes every next value; this bank only stores them
// and applies the reset values (synchronous, active-low).
module apb_out_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] paddr_d_i,
    input  logic [DATA_W-1:0] pwdata_d_i,
    input  logic              pwrite_d_i,
    input  logic [2:0]        pselx_d_i,
    input  logic              penable_d_i,
    input  logic              hreadyout_d_i,
    output logic [ADDR_W-1:0] paddr_q_o,
    output logic [DATA_W-1:0] pwdata_q_o,
    output logic              pwrite_q_o,
    output logic [2:0]        pselx_q_o,
    output logic              penable_q_o,
    output logic              hreadyout_q_o
);

    // Output register bank; reset leaves the bus idle and the AHB side ready.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            paddr_q_o     <= '0;
            pwdata_q_o    <= '0;
            pwrite_q_o    <= 1'b0;
            pselx_q_o     <= 3'b000;
            penable_q_o   <= 1'b0;
            hreadyout_q_o <= 1'b1;
        end else begin
            paddr_q_o     <= paddr_d_i;
            pwdata_q_o    <= pwdata_d_i;
            pwrite_q_o    <= pwrite_d_i;
            pselx_q_o     <= pselx_d_i;
            penable_q_o   <= penable_d_i;
            hreadyout_q_o <= hreadyout_d_i;
        end
    end

endmodule

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: APB-side control stage of the AHB-to-APB bridge.
// Sequences APB SETUP/ENABLE phases from the decoded AHB transfer and
// stalls the AHB master through Hreadyout while a transfer is pending.
// Optional feature macro: APB_WAIT_EN (adds Pready and APB wait states).
//
// Handshake: the AHB master may only advance when Hreadyout=1 at the end
// of a cycle; the controller drops Hreadyout in SETUP states (and, with
// APB_WAIT_EN, in ENABLE states while Pready=0). An APB ENABLE phase
// completes at the first rising edge where Pready=1 (always, without
// APB_WAIT_EN); Pselx/Paddr/Pwdata/Pwrite are stable from SETUP until then.
module apb_fsm_controller
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic [DATA_W-1:0] Prdata,
`ifdef APB_WAIT_EN
    input  logic              Pready,
`endif
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp,
    output logic [2:0]        dbg_state_o
);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic              enable_done;
    logic              setup_entry;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [2:0]        pselx_q;
    logic [2:0]        pselx_d;
    logic              penable_q;
    logic              penable_d;
    logic              hreadyout_q;
    logic              hreadyout_d;

`ifdef APB_WAIT_EN
    // An ENABLE phase only retires once the peripheral signals ready.
    assign enable_done = Pready;
`else
    // Without wait states every ENABLE phase lasts exactly one cycle.
    assign enable_done = 1'b1;
`endif

    // State register.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; valid is looked at only where a branch needs it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid && Hwrite) begin
                    state_d = ST_WWAIT;
                end else if (valid) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WWAIT: begin
                state_d = valid ? ST_WRITEP : ST_WRITE;
            end
            ST_READ: begin
                state_d = ST_RENABLE;
            end
            ST_WRITE: begin
                state_d = valid ? ST_WENABLEP : ST_WENABLE;
            end
            ST_WRITEP: begin
                state_d = ST_WENABLEP;
            end
            ST_RENABLE, ST_WENABLE: begin
                if (enable_done) begin
                    if (valid && !Hwrite) begin
                        state_d = ST_READ;
                    end else if (valid && Hwrite) begin
                        state_d = ST_WWAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WENABLEP: begin
                if (enable_done) begin
                    if (!Hwritereg) begin
                        state_d = ST_READ;
                    end else if (valid) begin
                        state_d = ST_WRITEP;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, decoded from the next state so the registered
    // outputs line up with the state register. Address, data and
    // direction are only loaded on entry to a SETUP state and otherwise
    // hold, which keeps them stable through ENABLE and any wait states.
    always_comb begin
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pselx_d     = pselx_q;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        setup_entry = 1'b0;
        unique case (state_d)
            ST_READ: begin
                paddr_d     = Haddr;
                pwrite_d    = 1'b0;
                hreadyout_d = 1'b0;
                setup_entry = 1'b1;
            end
            ST_WRITE: begin
                paddr_d     = Haddr1;
                pwdata_d    = Hwdata;
                pwrite_d    = 1'b1;
                hreadyout_d = 1'b0;
                setup_entry = 1'b1;
            end
            ST_WRITEP: begin
                paddr_d     = Haddr2;
                pwdata_d    = Hwdata1;
                pwrite_d    = 1'b1;
                hreadyout_d = 1'b0;
                setup_entry = 1'b1;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d = 1'b1;
            end
            default: begin
                // IDLE and WWAIT: no peripheral selected.
                pselx_d = 3'b000;
            end
        endcase
        if (setup_entry) begin
            pselx_d = apb_sel_decode(32'(paddr_d));
        end
    end

    apb_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i         (Hclk),
        .rst_ni        (Hresetn),
        .paddr_d_i     (paddr_d),
        .pwdata_d_i    (pwdata_d),
        .pwrite_d_i    (pwrite_d),
        .pselx_d_i     (pselx_d),
        .penable_d_i   (penable_d),
        .hreadyout_d_i (hreadyout_d),
        .paddr_q_o     (paddr_q),
        .pwdata_q_o    (pwdata_q),
        .pwrite_q_o    (pwrite_q),
        .pselx_q_o     (pselx_q),
        .penable_q_o   (penable_q),
        .hreadyout_q_o (hreadyout_q)
    );

    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;
    assign Pwrite  = pwrite_q;
    assign Pselx   = pselx_q;
    assign Penable = penable_q;

`ifdef APB_WAIT_EN
    // The registered ready is 1 throughout ENABLE; a stalled peripheral
    // must stall the AHB master in the same cycle, so mask it here.
    assign Hreadyout = hreadyout_q & ~(penable_q & ~Pready);
`else
    assign Hreadyout = hreadyout_q;
`endif

    assign Hrdata      = Prdata;
    assign Hresp       = HRESP_OKAY;
    assign dbg_state_o = state_q;

endmodule
